// File: rtl/e_mem_compress_writer_if.sv
// Row-input / E-memory-write bundle for the compressed check-node writer.
// The master side feeds rows of V2C messages; the slave side is the writer itself.
interface e_mem_compress_writer_if #(
  parameter int ADDRWIDTH = 9,
  parameter int W         = 6,
  parameter int ECOMPSIZE = 47
);
  logic                 start;
  logic [ADDRWIDTH-1:0] addr;
  logic                 q_valid;
  logic [W-1:0]         q_data;
  logic                 q_ready;
  logic [ECOMPSIZE-1:0] DIN;
  logic [ADDRWIDTH-1:0] WR_ADDRESS;
  logic                 wr;
  logic                 busy;
  logic                 done;

  modport master (
    output start, addr, q_valid, q_data,
    input  q_ready, DIN, WR_ADDRESS, wr, busy, done
  );

  modport slave (
    input  start, addr, q_valid, q_data,
    output q_ready, DIN, WR_ADDRESS, wr, busy, done
  );
endinterface

// File: rtl/e_mem_compress_writer.sv
// Compresses one LDPC row of Wc signed V2C messages into {sign, idx, min2, min1}
// and writes the packed word once to the E memory.
module e_mem_compress_writer #(
  parameter int DEPTH     = 512,
  parameter int ADDRWIDTH = 9,
  parameter int Wc        = 32,
  parameter int Wcbits    = 5,
  parameter int W         = 6
) (
  input logic                    clk,
  input logic                    rst,
  e_mem_compress_writer_if.slave bus
);
  localparam int Wabs      = W - 1;
  localparam int ECOMPSIZE = 2 * Wabs + Wcbits + Wc;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACC   = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;

  localparam logic [Wcbits-1:0] CNT_LAST = Wcbits'(Wc - 1);

  generate
    if (DEPTH > (1 << ADDRWIDTH) || Wc > (1 << Wcbits)) begin : g_param_check
      $error("e_mem_compress_writer: ADDRWIDTH or Wcbits too narrow");
    end
  endgenerate

  logic [1:0]           state;
  logic [ADDRWIDTH-1:0] addr_q;
  logic [Wabs-1:0]      min1;
  logic [Wabs-1:0]      min2;
  logic [Wcbits-1:0]    idx;
  logic [Wcbits-1:0]    cnt;
  logic [Wc-1:0]        sign;

  logic [W-1:0]         q_neg;
  logic [Wabs-1:0]      mag;
  logic [Wabs-1:0]      min1_nxt;
  logic [Wabs-1:0]      min2_nxt;
  logic [Wcbits-1:0]    idx_nxt;
  logic [Wc-1:0]        sign_nxt;
  logic [ECOMPSIZE-1:0] packed_nxt;

  assign bus.q_ready = (state == ACC);
  assign bus.busy    = (state == ACC) || (state == WRITE);

  // Saturating magnitude: the most negative code has no positive twin, so it
  // folds onto the largest representable magnitude.
  always_comb begin
    q_neg = -bus.q_data;
    if (!bus.q_data[W-1]) begin
      mag = bus.q_data[Wabs-1:0];
    end else if (q_neg[W-1]) begin
      mag = '1;
    end else begin
      mag = q_neg[Wabs-1:0];
    end
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    min1_nxt       = min1;
    min2_nxt       = min2;
    idx_nxt        = idx;
    sign_nxt       = sign;
    sign_nxt[cnt]  = bus.q_data[W-1];
    if (mag < min1) begin
      min2_nxt = min1;
      min1_nxt = mag;
      idx_nxt  = cnt;
    end else if (mag < min2) begin
      min2_nxt = mag;
    end
    packed_nxt = {sign_nxt, idx_nxt, min2_nxt, min1_nxt};
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      addr_q         <= '0;
      min1           <= '1;
      min2           <= '1;
      idx            <= '0;
      sign           <= '0;
      cnt            <= '0;
      bus.DIN        <= '0;
      bus.WR_ADDRESS <= '0;
      bus.wr         <= 1'b0;
      bus.done       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            addr_q <= bus.addr;
            min1   <= '1;
            min2   <= '1;
            idx    <= '0;
            sign   <= '0;
            cnt    <= '0;
            state  <= ACC;
          end
        end

        ACC: begin
          if (bus.q_valid) begin
            min1 <= min1_nxt;
            min2 <= min2_nxt;
            idx  <= idx_nxt;
            sign <= sign_nxt;
            cnt  <= cnt + 1'b1;
            // The final beat is folded straight into the output word.
            if (cnt == CNT_LAST) begin
              bus.DIN        <= packed_nxt;
              bus.WR_ADDRESS <= addr_q;
              bus.wr         <= 1'b1;
              bus.done       <= 1'b1;
              state          <= WRITE;
            end
          end
        end

        WRITE: begin
          bus.wr   <= 1'b0;
          bus.done <= 1'b0;
          state    <= IDLE;
        end

        default: begin
          bus.wr   <= 1'b0;
          bus.done <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_e_mem_compress_writer.sv
// Scoreboard bench: rows are driven with directed and random data; a min-search
// reference model predicts each E memory write and a monitor checks every wr.
module tb_e_mem_compress_writer;
  localparam int ADDRWIDTH = 9;
  localparam int Wc        = 32;
  localparam int Wcbits    = 5;
  localparam int W         = 6;
  localparam int Wabs      = W - 1;
  localparam int ECOMPSIZE = 2 * Wabs + Wcbits + Wc;
  localparam int MAGMAX    = (1 << Wabs) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  e_mem_compress_writer_if #(.ADDRWIDTH(ADDRWIDTH), .W(W), .ECOMPSIZE(ECOMPSIZE)) bus ();

  e_mem_compress_writer #(
    .DEPTH(512), .ADDRWIDTH(ADDRWIDTH), .Wc(Wc), .Wcbits(Wcbits), .W(W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [ADDRWIDTH-1:0] addr;
    logic [ECOMPSIZE-1:0] din;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks   = 0;
  int   errors   = 0;
  int   cyc      = 0;
  int   wr_count = 0;
  int   rows_expected = 0;
  int   row[Wc];

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: min1 is the smallest saturated magnitude, idx its first
  // occurrence, min2 the smallest magnitude among all other positions.
  function automatic logic [ECOMPSIZE-1:0] model(input int d[Wc]);
    int            mags[Wc];
    logic [Wc-1:0] s;
    int            m1, m2, i1;
    s  = '0;
    m1 = MAGMAX;
    m2 = MAGMAX;
    i1 = -1;
    for (int k = 0; k < Wc; k++) begin
      mags[k] = (d[k] < 0) ? -d[k] : d[k];
      if (mags[k] > MAGMAX) mags[k] = MAGMAX;
      s[k] = (d[k] < 0);
      if (mags[k] < m1) m1 = mags[k];
    end
    for (int k = 0; k < Wc; k++)
      if (i1 < 0 && mags[k] == m1) i1 = k;
    for (int k = 0; k < Wc; k++)
      if (k != i1 && mags[k] < m2) m2 = mags[k];
    return {s, Wcbits'(i1), Wabs'(m2), Wabs'(m1)};
  endfunction

  always @(negedge clk) begin
    if (bus.wr) begin
      wr_count++;
      if (sb.size() == 0) begin
        check("unexpected_wr", 64'd1, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        check("din", 64'(bus.DIN), 64'(mon_e.din));
        check("wr_address", 64'(bus.WR_ADDRESS), 64'(mon_e.addr));
      end
      check("done_with_wr", 64'(bus.done), 64'd1);
      check("busy_in_write", 64'(bus.busy), 64'd1);
      check("q_ready_in_write", 64'(bus.q_ready), 64'd0);
    end else if (bus.done) begin
      check("done_without_wr", 64'(bus.done), 64'd0);
    end
  end

  // Called at #1 after a posedge; leaves at #1 after a posedge in the cycle
  // following done (or following the reset pulse for an aborted row).
  // gap_mode: 0 = q_valid held high, 1 = invalid/valid alternating, 2 = random.
  task automatic run_row(input logic [ADDRWIDTH-1:0] a, input int gap_mode,
                         input bit inject_start, input int abort_after);
    int k = 0;
    int gaps = 0;
    int t = 0;
    int start_cyc;
    bit phase = 1'b0;
    bit valid;
    bus.start   = 1'b1;
    bus.addr    = a;
    bus.q_valid = 1'b0;
    start_cyc   = cyc;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.addr  = ADDRWIDTH'($urandom);
    if (abort_after < 0) begin
      sb.push_back('{a, model(row)});
      rows_expected++;
    end
    check("q_ready_in_acc", 64'(bus.q_ready), 64'd1);
    while (k < Wc && k != abort_after) begin
      case (gap_mode)
        0:       valid = 1'b1;
        1:       valid = phase;
        default: valid = ($urandom_range(0, 2) != 0);
      endcase
      phase       = ~phase;
      bus.q_valid = valid;
      bus.q_data  = valid ? W'(row[k]) : W'($urandom);
      bus.start   = inject_start && ($urandom_range(0, 3) == 0);
      bus.addr    = ADDRWIDTH'($urandom);
      @(posedge clk); #1;
      if (valid) k++;
      else gaps++;
    end
    bus.q_valid = 1'b0;
    bus.start   = 1'b0;
    if (abort_after >= 0) begin
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("abort_busy", 64'(bus.busy), 64'd0);
      check("abort_q_ready", 64'(bus.q_ready), 64'd0);
      check("abort_wr", 64'(bus.wr), 64'd0);
      return;
    end
    while (!bus.wr && t < 8) begin
      @(posedge clk); #1;
      t++;
    end
    check("latency", (t < 8) ? 64'(cyc - start_cyc) : 64'hFFFF, 64'(Wc + 1 + gaps));
    bus.start = inject_start;
    bus.addr  = ADDRWIDTH'($urandom);
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("wr_one_cycle", 64'(bus.wr), 64'd0);
  endtask

  task automatic load_test1();
    row[0] = 3; row[1] = -7; row[2] = 2; row[3] = 5;
    for (int k = 4; k < Wc; k++) row[k] = 15;
  endtask

  task automatic load_test3();
    row[0] = 9; row[1] = 4; row[2] = 4; row[3] = 6;
    for (int k = 4; k < Wc; k++) row[k] = 20;
  endtask

  task automatic load_random();
    bit narrow = $urandom_range(0, 1) == 1;
    for (int k = 0; k < Wc; k++)
      row[k] = narrow ? $urandom_range(0, 8) - 4 : $urandom_range(0, 63) - 32;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b1;
    bus.start   = 1'b0;
    bus.addr    = '0;
    bus.q_valid = 1'b0;
    bus.q_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_wr", 64'(bus.wr), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_q_ready", 64'(bus.q_ready), 64'd0);
    check("rst_din", 64'(bus.DIN), 64'd0);
    check("rst_wr_address", 64'(bus.WR_ADDRESS), 64'd0);
    rst = 1'b0;

    // q_valid while idle must neither be accepted nor start a row.
    bus.q_valid = 1'b1;
    bus.q_data  = 6'h01;
    repeat (3) @(posedge clk);
    #1;
    check("idle_q_ready", 64'(bus.q_ready), 64'd0);
    check("idle_busy", 64'(bus.busy), 64'd0);
    bus.q_valid = 1'b0;

    load_test1();
    run_row(9'h05A, 0, 1'b0, -1);
    for (int k = 0; k < Wc; k++) row[k] = -32;
    run_row(9'h011, 0, 1'b0, -1);
    load_test3();
    run_row(9'h0C3, 0, 1'b0, -1);
    load_test1();
    run_row(9'h05A, 1, 1'b0, -1);

    load_random();
    run_row(9'h123, 0, 1'b0, 10);
    load_test3();
    run_row(9'h1FF, 0, 1'b0, -1);

    load_test1();
    run_row(9'h0AA, 0, 1'b1, -1);
    load_test3();
    run_row(9'h055, 0, 1'b1, -1);

    for (int r = 0; r < 24; r++) begin
      load_random();
      run_row(ADDRWIDTH'($urandom), $urandom_range(0, 2), $urandom_range(0, 1) == 1,
              ($urandom_range(0, 7) == 0) ? $urandom_range(0, Wc - 1) : -1);
    end

    repeat (4) @(posedge clk);
    #1;
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    check("wr_count", 64'(wr_count), 64'(rows_expected));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
